// File: rtl/count_mon_pkg.sv
// Shared types for the counter monitor.
//   evt_type_t : two-bit event class carried in the top bits of each record
//   evt_t      : packed record {etype, value} at the nominal counter width
//   CntW/EvtW  : nominal counter width and record width
package count_mon_pkg;

  localparam int unsigned CntW = 4;
  localparam int unsigned EvtW = 2 + CntW;

  typedef enum logic [1:0] {
    Match  = 2'b00,
    WrapUp = 2'b01,
    WrapDn = 2'b10,
    Jump   = 2'b11
  } evt_type_t;

  typedef struct packed {
    evt_type_t        etype;
    logic [CntW-1:0]  value;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO for event records.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when full
//                with a same-cycle pop
//   pop, dout  : read request and head data; dout reads 0 while empty
//   full, empty: occupancy status
module evt_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = 1;

  // Pointers carry an extra lap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this edge.
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/count_monitor.sv
// Observer for a WIDTH-bit up/down counter. Classifies each sample-to-sample
// transition, queues at most one event record per cycle and keeps a saturating
// wrap tally plus a sticky drop flag.
//   clk, reset           : clock and synchronous active-high reset
//   cnt_in, cmp_val      : counter value and compare value, sampled every cycle
//   clr                  : clears wrap_cnt and overflow (FIFO untouched)
//   evt_valid/ready/data : record stream {type[1:0], value[WIDTH-1:0]}
//   wrap_cnt             : saturating count of wrap-up/wrap-down transitions
//   overflow             : sticky, a record was dropped on a full FIFO
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic [WIDTH-1:0]  cmp_val,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [WIDTH+1:0]  evt_data,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              overflow
);

  localparam logic [WIDTH-1:0]  One     = 1;
  localparam logic [WRAP_W-1:0] WrapOne = 1;

  logic [WIDTH-1:0]  prev_q;
  logic              prev_vld_q;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              overflow_q, overflow_d;

  logic [WIDTH-1:0]  prev_inc, prev_dec;
  logic              is_hold, is_wrap_up, is_wrap_dn, is_step, is_jump, is_match;
  logic              evt_push;
  evt_type_t         evt_type;
  logic [WIDTH+1:0]  evt_rec;

  logic              fifo_full, fifo_empty, fifo_pop;

  // Previous-sample register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= cnt_in;
      prev_vld_q <= 1'b1;
    end
  end

  // Transition classification and priority (Jump > Wrap > Match).
  always_comb begin
    prev_inc   = prev_q + One;
    prev_dec   = prev_q - One;
    is_hold    = (cnt_in == prev_q);
    is_wrap_up = (prev_q == '1) && (cnt_in == '0);
    is_wrap_dn = (prev_q == '0) && (cnt_in == '1);
    // Modular +-1 minus the boundary crossings, which are wraps instead.
    is_step    = ((cnt_in == prev_inc) || (cnt_in == prev_dec)) &&
                 !is_wrap_up && !is_wrap_dn;
    is_jump    = !is_hold && !is_step && !is_wrap_up && !is_wrap_dn;
    is_match   = (cnt_in == cmp_val) && !is_hold;

    evt_type = Match;
    evt_push = 1'b0;
    if (prev_vld_q) begin
      if (is_jump) begin
        evt_type = Jump;
        evt_push = 1'b1;
      end else if (is_wrap_up) begin
        evt_type = WrapUp;
        evt_push = 1'b1;
      end else if (is_wrap_dn) begin
        evt_type = WrapDn;
        evt_push = 1'b1;
      end else if (is_match) begin
        evt_type = Match;
        evt_push = 1'b1;
      end
    end
    evt_rec = {evt_type, cnt_in};
  end

  assign fifo_pop = evt_valid && evt_ready;

  evt_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (evt_push),
    .din   (evt_rec),
    .pop   (fifo_pop),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;

  // Tally and sticky flag; clr wins over a same-cycle update.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    overflow_d = overflow_q;
    if (clr) begin
      wrap_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (prev_vld_q && (is_wrap_up || is_wrap_dn) && (wrap_cnt_q != '1)) begin
        wrap_cnt_d = wrap_cnt_q + WrapOne;
      end
      if (evt_push && fifo_full && !fifo_pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;
  import count_mon_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic [3:0] cmp_val;
  logic       clr;
  logic       evt_valid;
  logic       evt_ready;
  logic [5:0] evt_data;
  logic [7:0] wrap_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [5:0] got[$];
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  count_monitor #(
    .WIDTH  (4),
    .DEPTH  (4),
    .WRAP_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .cmp_val   (cmp_val),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .wrap_cnt  (wrap_cnt),
    .overflow  (overflow)
  );

  // Inputs change 1ns after posedge, so a handshake seen at negedge is the
  // one the next posedge completes.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) got.push_back(evt_data);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] v);
    cnt_in = v;
    tick(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; cnt_in = 4'd0; cmp_val = 4'd0; clr = 1'b0; evt_ready = 1'b1;
    tick(3);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    checks++; if (evt_data !== 6'd0) begin errors++; $display("FAIL reset_data got %h want 00", evt_data); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap got %0d want 0", wrap_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_count_up;
    got.delete();
    cmp_val = 4'd9;
    for (int v = 1; v <= 16; v++) drive(4'(v));
    tick(3);
    exp_q = '{{Match, 4'd9}, {WrapUp, 4'd0}};
    checks++; if (got.size() != 2) begin errors++; $display("FAIL up_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL up_rec%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL up_wrap got %0d want 1", wrap_cnt); end
  endtask

  task automatic test_count_down;
    got.delete();
    cmp_val = 4'd15;
    clr = 1'b1; drive(4'd1); clr = 1'b0;
    drive(4'd0);
    drive(4'd15);
    tick(3);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL dn_count got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== {WrapDn, 4'd15}) begin errors++; $display("FAIL dn_rec got %h want %h", got[0], {WrapDn, 4'd15}); end
    end
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL dn_wrap got %0d want 1", wrap_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dn_ovf got %b want 0", overflow); end
  endtask

  task automatic test_jump_hold;
    drive(4'd3);
    tick(2);
    got.delete();
    cmp_val = 4'd12;
    drive(4'd12);
    tick(5);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL jump_count got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== {Jump, 4'd12}) begin errors++; $display("FAIL jump_rec got %h want %h", got[0], {Jump, 4'd12}); end
    end
  endtask

  task automatic test_overflow;
    logic [3:0] vals [5];
    vals = '{4'd2, 4'd7, 4'd2, 4'd7, 4'd2};
    got.delete();
    cmp_val = 4'd0;
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(vals[i]);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if (evt_data !== {Jump, 4'd2}) begin errors++; $display("FAIL ovf_head got %h want %h", evt_data, {Jump, 4'd2}); end
    evt_ready = 1'b1;
    tick(6);
    exp_q = '{{Jump, 4'd2}, {Jump, 4'd7}, {Jump, 4'd2}, {Jump, 4'd7}};
    checks++; if (got.size() != 4) begin errors++; $display("FAIL ovf_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_rec%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %b want 0", evt_valid); end
    clr = 1'b1; tick(1); clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    got.delete();
    evt_ready = 1'b0;
    drive(4'd9); drive(4'd4); drive(4'd9); drive(4'd4);
    evt_ready = 1'b1;
    drive(4'd11);
    evt_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    checks++; if (evt_data !== {Jump, 4'd4}) begin errors++; $display("FAIL fpp_head got %h want %h", evt_data, {Jump, 4'd4}); end
    // Still full: one more push with no pop must drop.
    drive(4'd6);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fpp_full got %b want 1", overflow); end
    evt_ready = 1'b1;
    tick(6);
    exp_q = '{{Jump, 4'd9}, {Jump, 4'd4}, {Jump, 4'd9}, {Jump, 4'd4}, {Jump, 4'd11}};
    checks++; if (got.size() != 5) begin errors++; $display("FAIL fpp_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_rec%0d got %h want %h", i, got[i], exp_q[i]); end
    end
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic test_saturate_clr;
    cmp_val = 4'd9;
    evt_ready = 1'b1;
    for (int v = 7; v <= 15; v++) drive(4'(v));
    for (int lap = 0; lap < 300; lap++) begin
      for (int v = 0; v <= 15; v++) drive(4'(v));
    end
    checks++; if (wrap_cnt !== 8'd255) begin errors++; $display("FAIL sat_wrap got %0d want 255", wrap_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf got %b want 0", overflow); end
    clr = 1'b1; drive(4'd0); clr = 1'b0;
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL clr_wrap got %0d want 0", wrap_cnt); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL clr_valid got %b want 1", evt_valid); end
    checks++; if (evt_data !== {WrapUp, 4'd0}) begin errors++; $display("FAIL clr_rec got %h want %h", evt_data, {WrapUp, 4'd0}); end
    tick(2);
  endtask

  task automatic test_reset_mid;
    evt_ready = 1'b0;
    drive(4'd15);
    drive(4'd8);
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL mid_prewrap got %0d want 1", wrap_cnt); end
    reset = 1'b1;
    tick(2);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", evt_valid); end
    checks++; if (evt_data !== 6'd0) begin errors++; $display("FAIL mid_data got %h want 00", evt_data); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL mid_wrap got %0d want 0", wrap_cnt); end
    got.delete();
    cmp_val = 4'd5;
    evt_ready = 1'b1;
    cnt_in = 4'd5;
    reset = 1'b0;
    tick(4);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL post_valid got %b want 0", evt_valid); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL post_count got %0d want 0", got.size()); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_count_down;
    test_jump_hold;
    test_overflow;
    test_full_push_pop;
    test_saturate_clr;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
